iob_cpu_mem_arb: RTL and testbench

IOB_CPU_MEM_ARB -- requirements
Module: iob_cpu_mem_arb

---
 rtl/iob_cpu_mem_arb.sv | 118 +++++++++++
 tb/tb_iob_cpu_mem_arb.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/iob_cpu_mem_arb.sv
// iob_cpu_mem_arb: merges a CPU instruction bus and data bus (IOb native)
// onto a single memory port. Only one transfer is in flight at a time; a
// read holds the port until its rvalid returns, writes complete on accept.
module iob_cpu_mem_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cke_i,

    input  logic                  i_avalid_i,
    input  logic [ADDR_W-1:0]     i_addr_i,
    input  logic [DATA_W-1:0]     i_wdata_i,
    input  logic [DATA_W/8-1:0]   i_wstrb_i,
    output logic [DATA_W-1:0]     i_rdata_o,
    output logic                  i_rvalid_o,
    output logic                  i_ready_o,

    input  logic                  d_avalid_i,
    input  logic [ADDR_W-1:0]     d_addr_i,
    input  logic [DATA_W-1:0]     d_wdata_i,
    input  logic [DATA_W/8-1:0]   d_wstrb_i,
    output logic [DATA_W-1:0]     d_rdata_o,
    output logic                  d_rvalid_o,
    output logic                  d_ready_o,

    output logic                  m_avalid_o,
    output logic [ADDR_W-1:0]     m_addr_o,
    output logic [DATA_W-1:0]     m_wdata_o,
    output logic [DATA_W/8-1:0]   m_wstrb_o,
    input  logic [DATA_W-1:0]     m_rdata_i,
    input  logic                  m_rvalid_i,
    input  logic                  m_ready_i
);

    localparam int STRB_W = DATA_W / 8;

    // Port identifiers used for owner / last_grant / selection.
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        WAIT_R = 1'b1
    } state_t;

    state_t             state_q;
    logic               owner_q;
    logic               last_grant_q;

    logic               any_req;
    logic               sel;
    logic [STRB_W-1:0]  sel_wstrb;
    logic               in_idle;
    logic               in_wait;
    logic               accept;

    // Request selection: a lone requester wins; on conflict the port that
    // was not granted last wins.
    always_comb begin
        any_req = i_avalid_i | d_avalid_i;
        if (i_avalid_i && d_avalid_i) begin
            sel = ~last_grant_q;
        end else begin
            sel = d_avalid_i ? PORT_D : PORT_I;
        end
        sel_wstrb = (sel == PORT_D) ? d_wstrb_i : i_wstrb_i;
    end

    assign in_idle = (state_q == IDLE);
    // Reset also masks rvalid so nothing leaks out while rst_i is held.
    assign in_wait = (state_q == WAIT_R) && !rst_i;

    // Request path: selected port drives the memory port while idle.
    assign m_avalid_o = in_idle & any_req;
    assign m_addr_o   = (sel == PORT_D) ? d_addr_i  : i_addr_i;
    assign m_wdata_o  = (sel == PORT_D) ? d_wdata_i : i_wdata_i;
    assign m_wstrb_o  = m_avalid_o ? sel_wstrb : '0;

    assign i_ready_o  = m_avalid_o & (sel == PORT_I) & m_ready_i;
    assign d_ready_o  = m_avalid_o & (sel == PORT_D) & m_ready_i;
    assign accept     = m_avalid_o & m_ready_i;

    // Response path: rvalid goes only to the owner of the outstanding read.
    assign i_rvalid_o = in_wait & (owner_q == PORT_I) & m_rvalid_i;
    assign d_rvalid_o = in_wait & (owner_q == PORT_D) & m_rvalid_i;
    assign i_rdata_o  = m_rdata_i;
    assign d_rdata_o  = m_rdata_i;

    // Arbitration FSM: track outstanding read owner and round-robin history.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            owner_q      <= PORT_I;
            last_grant_q <= PORT_I;
        end else if (cke_i) begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        last_grant_q <= sel;
                        if (sel_wstrb == '0) begin
                            owner_q <= sel;
                            state_q <= WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    if (m_rvalid_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_cpu_mem_arb.sv
// tb_iob_cpu_mem_arb: directed checks of the CPU instruction/data bus
// arbiter with hand-computed expected values.
module tb_iob_cpu_mem_arb;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cke_i;
    logic        i_avalid_i;
    logic [31:0] i_addr_i;
    logic [31:0] i_wdata_i;
    logic [3:0]  i_wstrb_i;
    logic [31:0] i_rdata_o;
    logic        i_rvalid_o;
    logic        i_ready_o;
    logic        d_avalid_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [3:0]  d_wstrb_i;
    logic [31:0] d_rdata_o;
    logic        d_rvalid_o;
    logic        d_ready_o;
    logic        m_avalid_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_wdata_o;
    logic [3:0]  m_wstrb_o;
    logic [31:0] m_rdata_i;
    logic        m_rvalid_i;
    logic        m_ready_i;

    int checks = 0;
    int errors = 0;

    iob_cpu_mem_arb #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cke_i(cke_i),
        .i_avalid_i(i_avalid_i), .i_addr_i(i_addr_i), .i_wdata_i(i_wdata_i),
        .i_wstrb_i(i_wstrb_i), .i_rdata_o(i_rdata_o), .i_rvalid_o(i_rvalid_o),
        .i_ready_o(i_ready_o),
        .d_avalid_i(d_avalid_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_wstrb_i(d_wstrb_i), .d_rdata_o(d_rdata_o), .d_rvalid_o(d_rvalid_o),
        .d_ready_o(d_ready_o),
        .m_avalid_o(m_avalid_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
        .m_wstrb_o(m_wstrb_o), .m_rdata_i(m_rdata_i), .m_rvalid_i(m_rvalid_i),
        .m_ready_i(m_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1; cke_i = 1'b1;
        i_avalid_i = 1'b0; i_addr_i = '0; i_wdata_i = '0; i_wstrb_i = '0;
        d_avalid_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_wstrb_i = '0;
        m_rdata_i = '0; m_rvalid_i = 1'b0; m_ready_i = 1'b1;

        // ---- reset state ----
        tick();
        m_rvalid_i = 1'b1;
        #1;
        chk("rst_m_avalid", 32'(m_avalid_o), 32'd0);
        chk("rst_m_wstrb",  32'(m_wstrb_o),  32'd0);
        chk("rst_i_ready",  32'(i_ready_o),  32'd0);
        chk("rst_d_ready",  32'(d_ready_o),  32'd0);
        chk("rst_i_rvalid", 32'(i_rvalid_o), 32'd0);
        chk("rst_d_rvalid", 32'(d_rvalid_o), 32'd0);
        tick();
        rst_i = 1'b0; m_rvalid_i = 1'b0;

        // ---- single ibus read at 0x100 ----
        i_avalid_i = 1'b1; i_addr_i = 32'h100; i_wstrb_i = 4'h0;
        #1;
        chk("rd_m_avalid", 32'(m_avalid_o), 32'd1);
        chk("rd_m_addr",   m_addr_o,        32'h100);
        chk("rd_i_ready",  32'(i_ready_o),  32'd1);
        chk("rd_d_ready",  32'(d_ready_o),  32'd0);
        tick();
        i_avalid_i = 1'b0;
        #1;
        chk("wr_m_avalid", 32'(m_avalid_o), 32'd0);
        chk("wr_i_rvalid", 32'(i_rvalid_o), 32'd0);
        tick();
        m_rvalid_i = 1'b1; m_rdata_i = 32'hDEADBEEF;
        #1;
        chk("rd_i_rvalid", 32'(i_rvalid_o), 32'd1);
        chk("rd_i_rdata",  i_rdata_o,       32'hDEADBEEF);
        chk("rd_d_rvalid", 32'(d_rvalid_o), 32'd0);
        tick();
        // back in IDLE: stray rvalid must be ignored
        #1;
        chk("idle_i_rvalid", 32'(i_rvalid_o), 32'd0);
        chk("idle_d_rvalid", 32'(d_rvalid_o), 32'd0);
        m_rvalid_i = 1'b0;

        // ---- simultaneous reads after reset: dbus first ----
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        i_avalid_i = 1'b1; i_addr_i = 32'h200; i_wstrb_i = 4'h0;
        d_avalid_i = 1'b1; d_addr_i = 32'h300; d_wstrb_i = 4'h0;
        #1;
        chk("rr1_d_ready", 32'(d_ready_o), 32'd1);
        chk("rr1_i_ready", 32'(i_ready_o), 32'd0);
        chk("rr1_m_addr",  m_addr_o,       32'h300);
        tick();
        d_avalid_i = 1'b0;
        m_rvalid_i = 1'b1; m_rdata_i = 32'h11111111;
        #1;
        chk("rr1_wait_i_ready", 32'(i_ready_o),  32'd0);
        chk("rr1_d_rvalid",     32'(d_rvalid_o), 32'd1);
        chk("rr1_i_rvalid",     32'(i_rvalid_o), 32'd0);
        chk("rr1_d_rdata",      d_rdata_o,       32'h11111111);
        tick();
        m_rvalid_i = 1'b0;
        #1;
        chk("rr2_i_ready", 32'(i_ready_o), 32'd1);
        chk("rr2_m_addr",  m_addr_o,       32'h200);
        tick();
        i_avalid_i = 1'b0;
        m_rvalid_i = 1'b1; m_rdata_i = 32'h22222222;
        #1;
        chk("rr2_i_rvalid", 32'(i_rvalid_o), 32'd1);
        chk("rr2_d_rvalid", 32'(d_rvalid_o), 32'd0);
        chk("rr2_i_rdata",  i_rdata_o,       32'h22222222);
        tick();
        m_rvalid_i = 1'b0;

        // ---- four back-to-back dbus writes ----
        for (int k = 0; k < 4; k++) begin
            d_avalid_i = 1'b1; d_addr_i = 32'h400 + 32'(4 * k);
            d_wdata_i = 32'hA000 + 32'(k); d_wstrb_i = 4'hF;
            #1;
            chk("bw_d_ready",  32'(d_ready_o),  32'd1);
            chk("bw_m_avalid", 32'(m_avalid_o), 32'd1);
            chk("bw_m_wstrb",  32'(m_wstrb_o),  32'hF);
            chk("bw_m_addr",   m_addr_o,        32'h400 + 32'(4 * k));
            chk("bw_m_wdata",  m_wdata_o,       32'hA000 + 32'(k));
            chk("bw_rvalid",   32'({i_rvalid_o, d_rvalid_o}), 32'd0);
            tick();
        end
        d_avalid_i = 1'b0;

        // ---- continuous simultaneous writes alternate d,i,d,i ----
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        i_avalid_i = 1'b1; i_addr_i = 32'h500; i_wstrb_i = 4'h3;
        d_avalid_i = 1'b1; d_addr_i = 32'h600; d_wstrb_i = 4'hF;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("alt_d_ready", 32'(d_ready_o), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("alt_i_ready", 32'(i_ready_o), (k % 2 == 0) ? 32'd0 : 32'd1);
            chk("alt_m_addr",  m_addr_o, (k % 2 == 0) ? 32'h600 : 32'h500);
            chk("alt_m_wstrb", 32'(m_wstrb_o), (k % 2 == 0) ? 32'hF : 32'h3);
            tick();
        end
        i_avalid_i = 1'b0; d_avalid_i = 1'b0;
        i_wstrb_i = 4'h0; d_wstrb_i = 4'h0;

        // ---- reset abandons an outstanding read ----
        i_avalid_i = 1'b1; i_addr_i = 32'h700;
        #1;
        chk("ab_i_ready", 32'(i_ready_o), 32'd1);
        tick();
        i_avalid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        rst_i = 1'b0;
        m_rvalid_i = 1'b1; m_rdata_i = 32'h33333333;
        #1;
        chk("ab_i_rvalid", 32'(i_rvalid_o), 32'd0);
        chk("ab_d_rvalid", 32'(d_rvalid_o), 32'd0);
        // IDLE again: a fresh request is offered to the memory port
        i_avalid_i = 1'b1;
        #1;
        chk("ab_idle_avalid", 32'(m_avalid_o), 32'd1);
        chk("ab_idle_i_ready", 32'(i_ready_o), 32'd1);
        tick();
        i_avalid_i = 1'b0;
        #1;
        chk("ab_new_i_rvalid", 32'(i_rvalid_o), 32'd1);
        tick();
        m_rvalid_i = 1'b0;

        // ---- clock enable low freezes WAIT_R ----
        d_avalid_i = 1'b1; d_addr_i = 32'h800; d_wstrb_i = 4'h0;
        #1;
        chk("ck_d_ready", 32'(d_ready_o), 32'd1);
        tick();
        d_avalid_i = 1'b0;
        cke_i = 1'b0;
        m_rvalid_i = 1'b1; m_rdata_i = 32'h44444444;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("ck_d_rvalid", 32'(d_rvalid_o), 32'd1);
            chk("ck_i_rvalid", 32'(i_rvalid_o), 32'd0);
            chk("ck_m_avalid", 32'(m_avalid_o), 32'd0);
            tick();
        end
        #1;
        chk("ck_hold_d_rvalid", 32'(d_rvalid_o), 32'd1);
        cke_i = 1'b1;
        tick();
        #1;
        chk("ck_idle_d_rvalid", 32'(d_rvalid_o), 32'd0);
        m_rvalid_i = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
